// File: rtl/axi_bram_log_drain_pkg.sv
// Shared definitions for the AXI transaction-log BRAM: entry layout and drain FSM states.
// Used by both the write-side logger and the read-side drain.
package axi_bram_log_drain_pkg;

    localparam int unsigned LOG_ENTRY_BITW = 96;

    localparam int unsigned TS_OFFSET   = 0;
    localparam int unsigned ADDR_OFFSET = 32;
    localparam int unsigned LEN_OFFSET  = 64;
    localparam int unsigned ID_OFFSET   = 72;

    typedef enum logic {
        ST_IDLE,
        ST_READING
    } drain_state_e;

endpackage

// File: rtl/log_entry_buf.sv
// Two-entry synchronous FIFO holding decoded log entries; slot0 is always the head.
module log_entry_buf #(
    parameter int unsigned DATA_BITW = 80
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  logic [DATA_BITW-1:0] push_data,
    input  logic                 pop,
    output logic [1:0]           count,
    output logic [DATA_BITW-1:0] head
);

    logic [DATA_BITW-1:0] slot0;
    logic [DATA_BITW-1:0] slot1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        slot0 <= push_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        slot0 <= push_data;
                    end else if (push) begin
                        slot1 <= push_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    // Full: a push is only accepted together with a pop.
                    if (pop) begin
                        slot0 <= slot1;
                        if (push) begin
                            slot1 <= push_data;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign head = slot0;

endmodule

// File: rtl/axi_bram_log_drain.sv
// Drains N entries from the transaction-log BRAM (entry 0 upward) and streams them
// decoded on a valid/ready interface, buffering at most two entries.
module axi_bram_log_drain
    import axi_bram_log_drain_pkg::*;
#(
    parameter int unsigned AXI_ID_BITW     = 8,
    parameter int unsigned TIMESTAMP_BITW  = 32,
    parameter int unsigned NUM_LOG_ENTRIES = 16384,
    parameter int unsigned AXI_ADDR_BITW   = 32,
    parameter int unsigned AXI_LEN_BITW    = 8,
    localparam int unsigned CNT_BITW       = $clog2(NUM_LOG_ENTRIES)
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RI,
    input  logic                      Start_SI,
    input  logic [CNT_BITW:0]         NumEntries_DI,
    input  logic                      Abort_SI,
    output logic                      Busy_SO,
    output logic                      Done_SO,
    output logic                      BramEn_SO,
    output logic [CNT_BITW-1:0]       BramAddr_DO,
    input  logic [LOG_ENTRY_BITW-1:0] BramRd_DI,
    output logic                      Valid_SO,
    input  logic                      Ready_SI,
    output logic                      Last_SO,
    output logic [TIMESTAMP_BITW-1:0] Timestamp_DO,
    output logic [AXI_ADDR_BITW-1:0]  AxiAddr_DO,
    output logic [AXI_LEN_BITW-1:0]   AxiLen_DO,
    output logic [AXI_ID_BITW-1:0]    AxiId_DO
);

    localparam int unsigned DATA_BITW = AXI_ID_BITW + AXI_LEN_BITW + AXI_ADDR_BITW + TIMESTAMP_BITW;
    localparam logic [CNT_BITW:0] MAX_ENTRIES = (CNT_BITW + 1)'(NUM_LOG_ENTRIES);
    localparam logic [CNT_BITW:0] ONE         = (CNT_BITW + 1)'(1);

    drain_state_e         state;
    logic [CNT_BITW:0]    total;
    logic [CNT_BITW:0]    rd_cnt;
    logic [CNT_BITW:0]    pop_cnt;
    logic                 inflight;
    logic                 done;

    logic [1:0]           occ;
    logic                 pop;
    logic                 issue;
    logic                 flush;
    logic                 last;
    logic [DATA_BITW-1:0] push_data;
    logic [DATA_BITW-1:0] head;
    logic                 unused_bram_bits;

    assign pop   = Valid_SO & Ready_SI;
    assign flush = Abort_SI && (state == ST_READING);
    assign last  = Valid_SO && (pop_cnt == (total - ONE));

    // A read may issue if the slot it will land in is free by the time it returns.
    assign issue = (state == ST_READING) && !Abort_SI && (rd_cnt < total) &&
                   (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    assign push_data = {BramRd_DI[ID_OFFSET   +: AXI_ID_BITW],
                        BramRd_DI[LEN_OFFSET  +: AXI_LEN_BITW],
                        BramRd_DI[ADDR_OFFSET +: AXI_ADDR_BITW],
                        BramRd_DI[TS_OFFSET   +: TIMESTAMP_BITW]};
    assign unused_bram_bits = ^BramRd_DI;

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state    <= ST_IDLE;
            total    <= '0;
            rd_cnt   <= '0;
            pop_cnt  <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                rd_cnt <= rd_cnt + ONE;
            end
            if (pop) begin
                pop_cnt <= pop_cnt + ONE;
            end
            case (state)
                ST_IDLE: begin
                    if (Start_SI) begin
                        if (NumEntries_DI == '0) begin
                            done <= 1'b1;
                        end else begin
                            total   <= (NumEntries_DI > MAX_ENTRIES) ? MAX_ENTRIES : NumEntries_DI;
                            rd_cnt  <= '0;
                            pop_cnt <= '0;
                            state   <= ST_READING;
                        end
                    end
                end
                default: begin
                    if (Abort_SI) begin
                        state <= ST_IDLE;
                    end else if (pop && last) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    log_entry_buf #(
        .DATA_BITW(DATA_BITW)
    ) u_buf (
        .clk      (Clk_CI),
        .rst      (Rst_RI),
        .flush    (flush),
        .push     (inflight),
        .push_data(push_data),
        .pop      (pop),
        .count    (occ),
        .head     (head)
    );

    assign Busy_SO      = (state == ST_READING);
    assign Done_SO      = done;
    assign BramEn_SO    = issue;
    assign BramAddr_DO  = rd_cnt[CNT_BITW-1:0];
    assign Valid_SO     = (occ != 2'd0);
    assign Last_SO      = last;
    assign Timestamp_DO = head[0 +: TIMESTAMP_BITW];
    assign AxiAddr_DO   = head[TIMESTAMP_BITW +: AXI_ADDR_BITW];
    assign AxiLen_DO    = head[TIMESTAMP_BITW + AXI_ADDR_BITW +: AXI_LEN_BITW];
    assign AxiId_DO     = head[TIMESTAMP_BITW + AXI_ADDR_BITW + AXI_LEN_BITW +: AXI_ID_BITW];

endmodule

// File: tb/tb_axi_bram_log_drain.sv
// Directed bench for axi_bram_log_drain with a 1-cycle-latency BRAM model holding
// entry i = {junk, id=i, len=i, addr=0x1000+i, ts=i}.
module tb_axi_bram_log_drain;

    localparam int unsigned NLOG = 1024;
    localparam int unsigned CNT  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CNT:0]  num_entries = '0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic          bram_en;
    logic [CNT-1:0] bram_addr;
    logic [95:0]   bram_rd = '0;
    logic          valid;
    logic          ready = 1'b0;
    logic          last;
    logic [31:0]   ts;
    logic [31:0]   axi_addr;
    logic [7:0]    axi_len;
    logic [7:0]    axi_id;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_bram_log_drain #(
        .AXI_ID_BITW    (8),
        .TIMESTAMP_BITW (32),
        .NUM_LOG_ENTRIES(NLOG)
    ) dut (
        .Clk_CI       (clk),
        .Rst_RI       (rst),
        .Start_SI     (start),
        .NumEntries_DI(num_entries),
        .Abort_SI     (abort),
        .Busy_SO      (busy),
        .Done_SO      (done),
        .BramEn_SO    (bram_en),
        .BramAddr_DO  (bram_addr),
        .BramRd_DI    (bram_rd),
        .Valid_SO     (valid),
        .Ready_SI     (ready),
        .Last_SO      (last),
        .Timestamp_DO (ts),
        .AxiAddr_DO   (axi_addr),
        .AxiLen_DO    (axi_len),
        .AxiId_DO     (axi_id)
    );

    function automatic logic [95:0] entry(input int unsigned i);
        logic [95:0] e;
        e        = '0;
        e[31:0]  = i;
        e[63:32] = 32'h1000 + i;
        e[71:64] = i[7:0];
        e[79:72] = i[7:0];
        e[95:80] = 16'hDEAD;
        return e;
    endfunction

    always @(posedge clk) begin
        if (bram_en) bram_rd <= entry(32'(bram_addr));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge, outputs are sampled 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic ready_at(input int pat, input int k);
        if (pat == 0) return 1'b1;
        return ((k % 4) == 0) || ((k % 4) == 3);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_en"},    64'(bram_en), 64'd0);
        check({tag, "_baddr"}, 64'(bram_addr), 64'd0);
        check({tag, "_valid"}, 64'(valid), 64'd0);
        check({tag, "_last"},  64'(last), 64'd0);
        check({tag, "_data"},  64'({ts, axi_addr}), 64'd0);
        check({tag, "_lenid"}, 64'({axi_len, axi_id}), 64'd0);
    endtask

    // Start a drain expecting num entries (drive = value on NumEntries), pat selects Ready pattern,
    // poke re-asserts Start mid-drain which must be ignored.
    task automatic drain(input int num, input int drive, input int pat, input bit poke,
                         output int first_valid, output int done_cyc);
        int got, rd_exp, n_done, last_hs, budget;
        bit stalled, hs;
        logic [31:0] held_ts, held_addr;
        got = 0; rd_exp = 0; n_done = 0; last_hs = -1; stalled = 0;
        first_valid = -1; done_cyc = -1; budget = 4 * num + 20;
        held_ts = '0; held_addr = '0;
        next_cycle();
        start = 1'b1; num_entries = (CNT + 1)'(drive); ready = ready_at(pat, 0);
        #1;
        for (int k = 1; k <= budget; k++) begin
            next_cycle();
            start = poke && (k == 4);
            num_entries = (poke && (k == 4)) ? (CNT + 1)'(3) : (CNT + 1)'(drive);
            ready = ready_at(pat, k);
            #1;
            if (stalled) begin
                check("hold_valid", 64'(valid), 64'd1);
                check("hold_ts", 64'(ts), 64'(held_ts));
                check("hold_addr", 64'(axi_addr), 64'(held_addr));
            end
            hs = valid && ready;
            stalled = valid && !ready;
            held_ts = ts;
            held_addr = axi_addr;
            if (valid && first_valid < 0) first_valid = k;
            if (bram_en) begin
                check("rd_addr", 64'(bram_addr), 64'(rd_exp));
                rd_exp++;
            end
            check("buf_bound", 64'((rd_exp - got) <= (2 + int'(hs))), 64'd1);
            if (hs) begin
                check("ts", 64'(ts), 64'(got));
                check("addr", 64'(axi_addr), 64'(32'h1000 + got));
                check("len", 64'(axi_len), 64'(got % 256));
                check("id", 64'(axi_id), 64'(got % 256));
                check("last", 64'(last), 64'(got == num - 1));
                got++;
                last_hs = k;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (done_cyc >= 0 && k >= done_cyc + 2) break;
        end
        start = 1'b0;
        check("drain_timeout", 64'(done_cyc >= 0), 64'd1);
        check("entries", 64'(got), 64'(num));
        check("reads", 64'(rd_exp), 64'(num));
        check("done_cnt", 64'(n_done), 64'd1);
        check("done_after_last", 64'(done_cyc), 64'(last_hs + 1));
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int fv, dc, popped;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;

        // Basic 4-entry drain, Ready held high.
        drain(4, 4, 0, 1'b0, fv, dc);
        check("t1_first_valid", 64'(fv), 64'd3);
        check("t1_done_cycle", 64'(dc), 64'd7);

        // 8 entries with Ready 1,0,0,1 and a Start pulse mid-drain.
        drain(8, 8, 1, 1'b1, fv, dc);
        check("t2_first_valid", 64'(fv), 64'd3);

        // Zero-length drain.
        next_cycle();
        start = 1'b1; num_entries = '0; ready = 1'b1;
        #1;
        check("zero_en0", 64'(bram_en), 64'd0);
        next_cycle();
        start = 1'b0;
        #1;
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_en1", 64'(bram_en), 64'd0);
        next_cycle();
        #1;
        check("zero_done_off", 64'(done), 64'd0);
        check("zero_busy2", 64'(busy), 64'd0);

        // Full-depth drain and an oversize request clamped to full depth.
        drain(NLOG, NLOG, 0, 1'b0, fv, dc);
        drain(NLOG, 2047, 0, 1'b0, fv, dc);

        // Abort with the buffer full after 3 entries consumed.
        next_cycle();
        start = 1'b1; num_entries = (CNT + 1)'(10); ready = 1'b1;
        #1;
        popped = 0;
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            start = 1'b0;
            ready = (popped < 3);
            #1;
            if (valid && ready) popped++;
        end
        check("ab_popped", 64'(popped), 64'd3);
        check("ab_full_valid", 64'(valid), 64'd1);
        check("ab_head_addr", 64'(axi_addr), 64'h1003);
        check("ab_full_noread", 64'(bram_en), 64'd0);
        check("ab_busy", 64'(busy), 64'd1);
        next_cycle();
        abort = 1'b1;
        #1;
        next_cycle();
        abort = 1'b0;
        #1;
        check("ab_idle", 64'(busy), 64'd0);
        check("ab_valid", 64'(valid), 64'd0);
        check("ab_en", 64'(bram_en), 64'd0);
        check("ab_done0", 64'(done), 64'd0);
        repeat (3) begin
            next_cycle();
            #1;
            check("ab_no_done", 64'(done), 64'd0);
        end
        drain(2, 2, 0, 1'b0, fv, dc);

        // Asynchronous reset mid-drain.
        next_cycle();
        start = 1'b1; num_entries = (CNT + 1)'(8); ready = 1'b1;
        #1;
        repeat (5) begin
            next_cycle();
            start = 1'b0;
            #1;
        end
        check("mid_valid", 64'(valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        next_cycle();
        rst = 1'b0;
        #1;
        repeat (3) begin
            next_cycle();
            #1;
            check("arst_no_done", 64'(done), 64'd0);
            check("arst_idle", 64'(busy), 64'd0);
        end
        drain(3, 3, 0, 1'b0, fv, dc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
